// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the Hi/Lo pair and serves MFHI/MFLO reads.
// Optional macro MD_EARLY_TERM_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mult,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_en,
    input  logic             rd_is_hi,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     hi, lo;
    logic                 dbz;

    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     divr;
    logic [WIDTH-1:0]     raw_a;
    logic                 op_mult, op_uns, neg_a, neg_res, b_zero;

    logic                 accept, calc_last;
    logic [WIDTH:0]       mul_sum, rem_t, diff;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                                 input logic uns);
        return (uns || !v[WIDTH-1]) ? v : -v;
    endfunction

    assign accept  = start && (state == IDLE || state == DONE);
    assign busy    = (state == CALC) || (state == FIX);
    assign done    = (state == DONE);
    assign rd_data = rd_en ? (rd_is_hi ? hi : lo) : '0;
    assign div_by_zero = dbz;

`ifdef MD_EARLY_TERM_EN
    logic [CNT_W-1:0] sh;
    assign calc_last = (cnt == CNT_W'(WIDTH - 1)) || (op_mult && divr[WIDTH-1:1] == '0);
    // cnt holds the number of shifts performed; realign the partial product
    assign sh        = CNT_W'(WIDTH) - cnt;
    assign prod      = acc >> sh;
`else
    assign calc_last = (cnt == CNT_W'(WIDTH - 1));
    assign prod      = acc;
`endif

    // multiply step: add multiplicand into the upper half, shift right; divr[0] is the current bit
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mcand} & {(WIDTH+1){divr[0]}});
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // restoring divide step: {remainder, dividend/quotient} shifts left one bit
    assign rem_t   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = rem_t - {1'b0, divr};
    assign div_nxt = {(diff[WIDTH] ? rem_t[WIDTH-1:0] : diff[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~diff[WIDTH]};

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (op_mult) begin
            {fix_hi, fix_lo} = (!op_uns && neg_res) ? -prod : prod;
        end else if (b_zero) begin
            fix_hi = raw_a;
            fix_lo = '1;
        end else begin
            fix_lo = (!op_uns && neg_res) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = (!op_uns && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (calc_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
                dbz <= 1'b0;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                hi  <= fix_hi;
                lo  <= fix_lo;
                dbz <= b_zero && !op_mult;
            end
        end
    end

    // operand latches and iteration datapath; only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            op_mult <= is_mult;
            op_uns  <= is_unsigned;
            mcand   <= abs_val(op_a, is_unsigned);
            divr    <= abs_val(op_b, is_unsigned);
            raw_a   <= op_a;
            neg_a   <= op_a[WIDTH-1];
            neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            b_zero  <= (op_b == '0);
            acc     <= is_mult ? '0 : {{WIDTH{1'b0}}, abs_val(op_a, is_unsigned)};
        end else if (state == CALC) begin
            if (op_mult) begin
                acc  <= mul_nxt;
                divr <= divr >> 1;
            end else begin
                acc  <= div_nxt;
            end
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide responder for the non-pipelined MIPS datapath. It consumes the control unit's md_is_mult, md_is_unsigned and lhr_wen strobes, runs MULT/MULTU/DIV/DIVU over multiple cycles, and owns the Lo/Hi register pair. It serves lhr_ren/lhr_is_hi reads for MFHI/MFLO. It reports busy/done so the datapath stalls the PC until the result lands.

Parameters:
WIDTH, 32, operand and Lo/Hi width; cycle counts below scale with it.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
start  input  1  request, driven from lhr_wen; sampled only in IDLE or DONE
is_mult  input  1  1 = MULT/MULTU, 0 = DIV/DIVU (md_is_mult)
is_unsigned  input  1  1 = unsigned op (md_is_unsigned)
op_a  input  WIDTH  rs value: multiplicand or dividend
op_b  input  WIDTH  rt value: multiplier or divisor
rd_en  input  1  read strobe (lhr_ren)
rd_is_hi  input  1  1 = Hi, 0 = Lo (lhr_is_hi)
rd_data  output  WIDTH  selected register; combinational; 0 when rd_en=0
busy  output  1  high from the cycle after accept through the FIX cycle
done  output  1  one-cycle pulse; Hi/Lo already hold the new result
div_by_zero  output  1  set by a divide with op_b==0; cleared on next accepted start

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low. While rst_n=0 at a clk edge: state<=IDLE, hi/lo<=0, busy=0, done=0, div_by_zero=0, counter<=0. Reset mid-operation aborts and discards partial results.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1: latch op, signedness, |op_a| and |op_b| (two's-complement absolute value when signed), the sign of op_a, and sign(op_a)^sign(op_b). Go to CALC with counter=0 and clear div_by_zero.
- DONE with start=0: go to IDLE.
- CALC, multiply: radix-2 shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first.
- CALC exit: after exactly WIDTH cycles, go to FIX.
- FIX: one cycle.
  - Signed multiply with sign(op_a)^sign(op_b)=1: negate the 2*WIDTH product. {hi,lo}<=product.
  - Divide: lo<=quotient, negated if the signs differ (signed only). hi<=remainder, negated if op_a was negative (signed only).
  - Divisor 0: override with lo<=all-ones and hi<=op_a (raw), for both signednesses; set div_by_zero.
- Then go to DONE.
- Latency: start accepted at edge of cycle T; CALC spans T+1..T+WIDTH; FIX is T+WIDTH+1; done=1 in T+WIDTH+2. Default WIDTH gives a 34-cycle start-to-done latency.
- Signed overflow: -2^31 / -1 gives lo=0x80000000, hi=0, no flag.
- start in CALC/FIX is ignored; no queuing. The control path must hold the PC while busy.
- hi/lo change only in FIX. rd_data returns the previous result during busy; there is no forwarding.
- Simultaneous start and rd_en in DONE: the read returns the just-completed result.

Optional Feature:
MD_EARLY_TERM_EN.
- Defined: in multiply CALC, go to FIX as soon as the remaining unshifted multiplier bits are all zero. Shift the accumulator to its final alignment in FIX. CALC lasts at least 1 cycle.
- Divide timing is unchanged.
- Not defined: fixed WIDTH-cycle CALC for every op.

Test Plan:
- Signed mult op_a=0xFFFFFFFD (-3), op_b=5 -> done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy high T+1..T+33.
- Unsigned mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned div 100/7 -> lo=14, hi=2.
- Div by zero, unsigned 100/0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1. The next start (mult 2*3) clears the flag; hi=0, lo=6.
- start pulsed at T+5 during busy -> ignored, a single done at T+34. rst_n=0 at T+10 -> IDLE, hi=lo=0, no done.
- With MD_EARLY_TERM_EN, unsigned 7*3 -> hi=0, lo=21, done well before T+34 (CALC ≤2 cycles). Without the macro, the same op gives done at T+34.
